uart_mem_dump: RTL and testbench
================================

// Module: uart_mem_dump
// PURPOSE
//  Read-back path for the 8b computer's 16x8 program/data RAM over the serial link.
//  On a start pulse, reads every RAM location through a synchronous read port and sends a framed
//  dump over UART TX: 8N1, LSB first, idle high.
//  Mirrors the serial write-in path, so a host can verify what it loaded.
// PARAMETERS
//  CLKS_PER_BIT  5208  clocks per UART bit (50 MHz / 9600 baud)
//  HDR_BYTE      8'hA5 first byte of every dump frame
//  TRL_BYTE      8'h5A last byte of every dump frame
// PORTS
//  CLOCK_50    in   1  single system clock; all state on rising edge
//  RESET_N     in   1  asynchronous, active-low reset
//  dump_start  in   1  1-cycle pulse; requests one full dump
//  mem_addr    out  4  RAM read address
//  mem_data    in   8  RAM read data; valid 1 clock after mem_addr changes (sync read)
//  busy        out  1  high from accepted dump_start until done
//  done        out  1  1-cycle pulse after trailer stop bit completes
//  UART_TXD    out  1  serial line, idle 1
// BEHAVIOUR
//  Reset values: UART_TXD=1, busy=0, done=0, mem_addr=0, FSM=IDLE, bit/baud counters=0.
//  RESET_N low mid-frame: line returns high immediately; no partial-frame recovery.
//  Frame: HDR_BYTE, then for a=0..15: {4'h0,a}, mem[a]; then TRL_BYTE. Total 34 bytes.
//  FSM states and transitions:
//   IDLE  -> HDR on dump_start; busy rises on the next edge.
//   HDR   -> send HDR_BYTE; on byte done -> RD.
//   RD    -> drive mem_addr=a -> WAIT.
//   WAIT  -> 1 cycle -> capture mem_data into value register -> SADDR.
//   SADDR -> send {4'h0,a} -> SVAL.
//   SVAL  -> send captured value;
//            a==15 -> TRL; otherwise a++ (4-bit, no wrap beyond 15) -> RD.
//   TRL   -> send TRL_BYTE -> DONE.
//   DONE  -> done=1 for 1 cycle, busy=0 -> IDLE.
//  dump_start while busy: ignored, not queued.
//  dump_start in the DONE cycle: ignored.
//  mem_addr holds its value between reads; RAM writes during a dump are not blocked.
//   The value captured in WAIT is the value sent.
//  Bit timing, per byte:
//   start bit 0, data[0]..data[7], stop bit 1; each bit exactly CLKS_PER_BIT clocks.
//  Inter-byte gap: next start bit begins <=2 clocks after previous stop bit ends.
//   This covers the RD/WAIT read gap.
//  Full dump completes within 34*(10*CLKS_PER_BIT+2)+4 clocks of dump_start.
//  Baud counter: $clog2(CLKS_PER_BIT) bits, counts 0..CLKS_PER_BIT-1 then wraps.
// STRUCTURE
//  Shared package/include:
//   FSM state encodings; HDR/TRL defaults; DUMP_BYTES=34; MEM_DEPTH=16.
//  Sub-module uart_tx_core (CLKS_PER_BIT):
//   in:  tx_dv, tx_byte[7:0]
//   out: tx_serial, tx_active, tx_done (1-cycle pulse at end of stop bit)
//   Same clock and reset; tx_dv ignored while tx_active.
//  uart_mem_dump holds the dump FSM, address counter and value register only.
// TESTING (CLKS_PER_BIT=4 for sim; bench UART monitor samples mid-bit)
//  1 Reset: RESET_N=0 -> UART_TXD=1, busy=0, done=0, mem_addr=0; stays idle 100 clks w/o start.
//  2 Full dump: RAM model mem[a]=8'h10+a, pulse dump_start.
//    -> bytes A5,00,10,01,11,...,0F,1F,5A; busy high throughout; one done pulse;
//       34 bytes within 34*42+4 clks.
//  3 Bit timing: byte A5 -> line 0,1,0,1,0,0,1,0,1,1.
//    Each level held exactly 4 clks; gap between bytes <=2 clks.
//  4 Retrigger: dump_start pulsed again at byte 10 and in the DONE cycle
//    -> still exactly 34 bytes and one done; no second dump.
//  5 Reset mid-dump: RESET_N low during byte 5 data bit 3
//    -> UART_TXD=1 same cycle, busy=0; a later dump_start gives a clean full 34-byte dump.
//  6 Sync read: RAM model returns X except 1 clk after addr change
//    -> no X on UART_TXD; mem[15]=8'hFF sent as FF before 5A.

Source files
------------

// File: rtl/uart_mem_dump_pkg.sv
// Shared types and constants for the RAM dump-over-UART path.
// Dump FSM and serialiser phase encodings live here.
package uart_mem_dump_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_RD,
    S_WAIT,
    S_SADDR,
    S_SVAL,
    S_TRL,
    S_DONE
  } dump_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_phase_t;

  localparam logic [7:0] HDR_DEFAULT = 8'hA5;
  localparam logic [7:0] TRL_DEFAULT = 8'h5A;
  localparam int DUMP_BYTES = 34;
  localparam int MEM_DEPTH = 16;
  localparam logic [3:0] LAST_ADDR = 4'(MEM_DEPTH - 1);

  function automatic logic [7:0] addr_byte(input logic [3:0] a);
    return {4'h0, a};
  endfunction

endpackage

// File: rtl/uart_mem_dump_tx.sv
// 8N1 UART serialiser, LSB first, idle high.
// tx_done is high during the last clock of the stop bit.
module uart_tx_core
  import uart_mem_dump_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_dv,
  input  logic [7:0] tx_byte,
  output logic       tx_serial,
  output logic       tx_active,
  output logic       tx_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  tx_phase_t     phase;
  tx_phase_t     phase_d;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          bit_end;

  assign bit_end   = (baud_cnt == BAUD_LAST);
  assign tx_active = (phase != TX_IDLE);
  assign tx_done   = (phase == TX_STOP) && bit_end;

  always_comb begin
    phase_d = phase;
    unique case (phase)
      TX_IDLE:  if (tx_dv) phase_d = TX_START;
      TX_START: if (bit_end) phase_d = TX_DATA;
      TX_DATA:  if (bit_end && bit_idx == 3'd7) phase_d = TX_STOP;
      TX_STOP:  if (bit_end) phase_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase     <= TX_IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      tx_serial <= 1'b1;
    end else begin
      phase <= phase_d;
      if (phase == TX_IDLE) begin
        baud_cnt <= '0;
        bit_idx  <= '0;
        if (tx_dv) begin
          shreg     <= tx_byte;
          tx_serial <= 1'b0;
        end
      end else if (!bit_end) begin
        baud_cnt <= baud_cnt + 1'b1;
      end else begin
        baud_cnt <= '0;
        if (phase_d == TX_STOP || phase_d == TX_IDLE) begin
          tx_serial <= 1'b1;
        end else begin
          // shreg[0] is the bit on the line while in DATA
          tx_serial <= (phase == TX_START) ? shreg[0] : shreg[1];
          if (phase == TX_DATA) begin
            shreg   <= shreg >> 1;
            bit_idx <= bit_idx + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/uart_mem_dump.sv
// Dumps the 16x8 RAM as a framed byte stream over UART TX.
// Frame: header, {addr, value} x16, trailer.
module uart_mem_dump
  import uart_mem_dump_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 5208,
  parameter logic [7:0] HDR_BYTE     = HDR_DEFAULT,
  parameter logic [7:0] TRL_BYTE     = TRL_DEFAULT
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       dump_start,
  output logic [3:0] mem_addr,
  input  logic [7:0] mem_data,
  output logic       busy,
  output logic       done,
  output logic       UART_TXD
);

  dump_state_t state;
  dump_state_t state_d;
  logic [3:0]  addr_d;
  logic [7:0]  value;
  logic        capture;
  logic        tx_dv;
  logic [7:0]  tx_byte;
  logic        tx_active;
  logic        tx_done;

  assign busy = (state != S_IDLE) && (state != S_DONE);
  assign done = (state == S_DONE);

  uart_tx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk      (CLOCK_50),
    .rst_n    (RESET_N),
    .tx_dv    (tx_dv),
    .tx_byte  (tx_byte),
    .tx_serial(UART_TXD),
    .tx_active(tx_active),
    .tx_done  (tx_done)
  );

  always_comb begin
    state_d = state;
    addr_d  = mem_addr;
    capture = 1'b0;
    tx_dv   = 1'b0;
    tx_byte = 8'h00;
    unique case (state)
      S_IDLE: if (dump_start) state_d = S_HDR;
      S_HDR: begin
        tx_dv   = !tx_active;
        tx_byte = HDR_BYTE;
        if (tx_done) begin
          state_d = S_RD;
          addr_d  = '0;
        end
      end
      S_RD: state_d = S_WAIT;
      S_WAIT: begin
        // address byte launches here to keep the read gap short
        capture = 1'b1;
        tx_dv   = 1'b1;
        tx_byte = addr_byte(mem_addr);
        state_d = S_SADDR;
      end
      S_SADDR: if (tx_done) state_d = S_SVAL;
      S_SVAL: begin
        tx_dv   = !tx_active;
        tx_byte = value;
        if (tx_done) begin
          if (mem_addr == LAST_ADDR) begin
            state_d = S_TRL;
          end else begin
            state_d = S_RD;
            addr_d  = mem_addr + 4'd1;
          end
        end
      end
      S_TRL: begin
        tx_dv   = !tx_active;
        tx_byte = TRL_BYTE;
        if (tx_done) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= S_IDLE;
      mem_addr <= '0;
      value    <= '0;
    end else begin
      state    <= state_d;
      mem_addr <= addr_d;
      if (capture) value <= mem_data;
    end
  end

endmodule

// File: tb/tb_uart_mem_dump.sv
// Bench for uart_mem_dump: line trace decoded into bytes
// and compared against a frame built from the RAM contents.
module tb_uart_mem_dump;
  import uart_mem_dump_pkg::*;

  localparam int CPB      = 4;
  localparam int FRAME    = 10 * CPB;
  localparam int MAX_CLKS = DUMP_BYTES * (FRAME + 2) + 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dump_start = 1'b0;
  logic [3:0] mem_addr;
  logic [7:0] mem_data;
  logic       busy;
  logic       done;
  logic       txd;

  logic [7:0] ram [16];
  logic       xmode = 1'b0;
  logic [3:0] last_addr = '0;

  int vectors = 0;
  int errors = 0;

  logic       line_q[$];
  logic [7:0] got_q[$];
  int         start_q[$];
  logic [7:0] exp_q[$];
  int         xcnt;
  int         done_cnt;
  int         done_at;
  int         busy_bad;

  always #5 clk = ~clk;

  uart_mem_dump #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .CLOCK_50  (clk),
    .RESET_N   (rst_n),
    .dump_start(dump_start),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .busy      (busy),
    .done      (done),
    .UART_TXD  (txd)
  );

  // synchronous-read RAM; in xmode data is valid only one clock after an address change
  always @(posedge clk) begin
    if (xmode && mem_addr === last_addr) mem_data <= 'x;
    else mem_data <= ram[mem_addr];
    last_addr <= mem_addr;
  end

  function automatic void build_exp();
    exp_q.delete();
    exp_q.push_back(HDR_DEFAULT);
    for (int a = 0; a < 16; a++) begin
      exp_q.push_back(8'(a));
      exp_q.push_back(ram[a]);
    end
    exp_q.push_back(TRL_DEFAULT);
  endfunction

  task automatic run_dump(input int retrig_at, input bit retrig_done, input int tail);
    int k;
    bit fin;
    line_q.delete();
    done_cnt = 0;
    done_at  = -1;
    busy_bad = 0;
    @(posedge clk); #1 dump_start = 1'b1;
    @(posedge clk); #1 dump_start = 1'b0;
    k = 0;
    fin = 1'b0;
    while (!fin) begin
      @(negedge clk);
      k++;
      dump_start = 1'b0;
      line_q.push_back(txd);
      if (done === 1'b1) begin
        done_cnt++;
        if (busy !== 1'b0) busy_bad++;
        if (done_at < 0) begin
          done_at = k;
          if (retrig_done) dump_start = 1'b1;
        end
      end else if (done_at < 0 && busy !== 1'b1) begin
        busy_bad++;
      end
      if (k == retrig_at) dump_start = 1'b1;
      if ((done_at >= 0 && k >= done_at + tail) || k >= MAX_CLKS + tail) fin = 1'b1;
    end
    dump_start = 1'b0;
  endtask

  task automatic decode();
    int i;
    int p;
    logic [7:0] b;
    got_q.delete();
    start_q.delete();
    xcnt = 0;
    foreach (line_q[n]) if (line_q[n] !== 1'b0 && line_q[n] !== 1'b1) xcnt++;
    i = 0;
    while (i < line_q.size()) begin
      if (line_q[i] === 1'b0) begin
        for (int n = 0; n < 8; n++) begin
          p = i + CPB * (n + 1) + CPB / 2;
          b[n] = (p < line_q.size()) ? line_q[p] : 1'b1;
        end
        got_q.push_back(b);
        start_q.push_back(i);
        i += FRAME;
      end else begin
        i++;
      end
    end
  endtask

  task automatic test_reset();
    int bad;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b want 1", txd); end
    vectors++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    vectors++;
    if (mem_addr !== 4'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
    @(negedge clk) rst_n = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || mem_addr !== 4'h0) bad++;
    end
    vectors++;
    if (bad != 0) begin errors++; $display("FAIL reset_idle: got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_full_dump();
    logic [7:0] g;
    for (int a = 0; a < 16; a++) ram[a] = 8'h10 + 8'(a);
    build_exp();
    run_dump(-1, 1'b0, 60);
    decode();
    vectors++;
    if (got_q.size() != DUMP_BYTES) begin
      errors++; $display("FAIL full_count: got %0d want %0d", got_q.size(), DUMP_BYTES);
    end
    foreach (exp_q[j]) begin
      g = (j < got_q.size()) ? got_q[j] : 8'h00;
      vectors++;
      if (j >= got_q.size() || g !== exp_q[j]) begin
        errors++; $display("FAIL full_byte%0d: got %h want %h", j, g, exp_q[j]);
      end
    end
    vectors++;
    if (done_cnt != 1) begin errors++; $display("FAIL full_done_cnt: got %0d want 1", done_cnt); end
    vectors++;
    if (done_at < 0 || done_at > MAX_CLKS) begin
      errors++; $display("FAIL full_latency: got %0d want <=%0d", done_at, MAX_CLKS);
    end
    vectors++;
    if (busy_bad != 0) begin errors++; $display("FAIL full_busy: got %0d bad want 0", busy_bad); end
  endtask

  task automatic test_bit_timing();
    logic [9:0] pat = 10'b1101001010;
    int s;
    int bad;
    int gap_bad;
    logic lvl;
    vectors++;
    if (start_q.size() == 0) begin
      errors++; $display("FAIL timing_hdr: got no frame want A5 frame");
    end else begin
      s = start_q[0];
      bad = 0;
      for (int t = 0; t < FRAME; t++)
        if (s + t >= line_q.size() || line_q[s + t] !== pat[t / CPB]) bad++;
      if (bad != 0) begin
        errors++; $display("FAIL timing_hdr: got %0d bad clocks want 0", bad);
      end
    end
    bad = 0;
    foreach (start_q[j]) begin
      if (j < exp_q.size()) begin
        for (int t = 0; t < FRAME; t++) begin
          if (t < CPB) lvl = 1'b0;
          else if (t >= 9 * CPB) lvl = 1'b1;
          else lvl = exp_q[j][t / CPB - 1];
          if (start_q[j] + t >= line_q.size() || line_q[start_q[j] + t] !== lvl) bad++;
        end
      end
    end
    vectors++;
    if (bad != 0) begin errors++; $display("FAIL timing_frames: got %0d bad clocks want 0", bad); end
    gap_bad = 0;
    for (int j = 1; j < start_q.size(); j++) begin
      s = start_q[j] - start_q[j - 1] - FRAME;
      if (s < 0 || s > 2) gap_bad++;
    end
    vectors++;
    if (gap_bad != 0) begin errors++; $display("FAIL timing_gap: got %0d bad gaps want 0", gap_bad); end
  endtask

  task automatic test_random_dump();
    logic [7:0] g;
    int bad;
    for (int r = 0; r < 2; r++) begin
      for (int a = 0; a < 16; a++) ram[a] = 8'($urandom);
      build_exp();
      run_dump(-1, 1'b0, 40);
      decode();
      bad = 0;
      foreach (exp_q[j]) begin
        g = (j < got_q.size()) ? got_q[j] : 8'h00;
        if (j >= got_q.size() || g !== exp_q[j]) bad++;
      end
      vectors++;
      if (got_q.size() != DUMP_BYTES || bad != 0) begin
        errors++;
        $display("FAIL rand%0d_bytes: got %0d bytes %0d wrong want %0d bytes 0 wrong",
                 r, got_q.size(), bad, DUMP_BYTES);
      end
      vectors++;
      if (done_cnt != 1 || busy_bad != 0) begin
        errors++; $display("FAIL rand%0d_ctrl: got done %0d busy_bad %0d want 1 0", r, done_cnt, busy_bad);
      end
    end
  endtask

  task automatic test_back_to_back();
    int bad;
    for (int a = 0; a < 16; a++) ram[a] = 8'($urandom);
    build_exp();
    // byte 10 starts between clock 402 and 422; 430 lands inside it
    run_dump(430, 1'b1, 200);
    decode();
    vectors++;
    if (got_q.size() != DUMP_BYTES) begin
      errors++; $display("FAIL retrig_count: got %0d want %0d", got_q.size(), DUMP_BYTES);
    end
    vectors++;
    if (done_cnt != 1) begin errors++; $display("FAIL retrig_done: got %0d want 1", done_cnt); end
    bad = 0;
    foreach (exp_q[j]) if (j >= got_q.size() || got_q[j] !== exp_q[j]) bad++;
    vectors++;
    if (bad != 0) begin errors++; $display("FAIL retrig_bytes: got %0d wrong want 0", bad); end
  endtask

  task automatic test_reset_mid_dump();
    int frames;
    int cnt;
    bit in_frame;
    bit hit;
    int bad;
    for (int a = 0; a < 16; a++) ram[a] = 8'($urandom);
    @(posedge clk); #1 dump_start = 1'b1;
    @(posedge clk); #1 dump_start = 1'b0;
    frames = 0;
    cnt = 0;
    in_frame = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < MAX_CLKS && !hit; k++) begin
      @(negedge clk);
      if (!in_frame && txd === 1'b0) begin
        in_frame = 1'b1;
        cnt = 0;
      end
      if (in_frame) begin
        cnt++;
        // clock 17 of the frame is mid data bit 3
        if (frames == 5 && cnt == 18) hit = 1'b1;
        if (cnt == FRAME) begin
          in_frame = 1'b0;
          frames++;
        end
      end
    end
    vectors++;
    if (!hit) begin errors++; $display("FAIL midrst_reach: got %0d frames want byte 5 bit 3", frames); end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (txd !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || mem_addr !== 4'h0) begin
      errors++;
      $display("FAIL midrst_out: got txd %b busy %b done %b addr %h want 1 0 0 0",
               txd, busy, done, mem_addr);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    build_exp();
    run_dump(-1, 1'b0, 40);
    decode();
    bad = 0;
    foreach (exp_q[j]) if (j >= got_q.size() || got_q[j] !== exp_q[j]) bad++;
    vectors++;
    if (got_q.size() != DUMP_BYTES || bad != 0 || done_cnt != 1) begin
      errors++;
      $display("FAIL midrst_redump: got %0d bytes %0d wrong %0d done want %0d 0 1",
               got_q.size(), bad, done_cnt, DUMP_BYTES);
    end
  endtask

  task automatic test_sync_read();
    logic [7:0] g;
    int bad;
    for (int a = 0; a < 16; a++) ram[a] = 8'($urandom) | 8'h01;
    ram[15] = 8'hFF;
    xmode = 1'b1;
    build_exp();
    run_dump(-1, 1'b0, 40);
    decode();
    xmode = 1'b0;
    vectors++;
    if (xcnt != 0) begin errors++; $display("FAIL sync_x: got %0d X samples want 0", xcnt); end
    bad = 0;
    foreach (exp_q[j]) if (j >= got_q.size() || got_q[j] !== exp_q[j]) bad++;
    vectors++;
    if (got_q.size() != DUMP_BYTES || bad != 0) begin
      errors++; $display("FAIL sync_bytes: got %0d bytes %0d wrong want %0d 0", got_q.size(), bad, DUMP_BYTES);
    end
    g = (got_q.size() > 32) ? got_q[32] : 8'h00;
    vectors++;
    if (g !== 8'hFF) begin errors++; $display("FAIL sync_last_val: got %h want ff", g); end
    g = (got_q.size() > 33) ? got_q[33] : 8'h00;
    vectors++;
    if (g !== 8'h5A) begin errors++; $display("FAIL sync_trailer: got %h want 5a", g); end
  endtask

  initial begin
    test_reset();
    test_full_dump();
    test_bit_timing();
    test_random_dump();
    test_back_to_back();
    test_reset_mid_dump();
    test_sync_read();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
